mips_cpu_bus_lsu: RTL

Load/store bus master between the MIPS CPU datapath and the word-addressed Avalon-style memory bus.
- Converts one byte, halfword or word load/store into a single word-aligned bus transaction with the correct byteenable and lane-shifted writedata.
- Honours waitrequest.
- Extracts and zero- or sign-extends the addressed bytes from readdata.
- Flags misaligned accesses without issuing a bus cycle.

---
 rtl/mips_cpu_bus_lsu.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/mips_cpu_bus_lsu.sv
// mips_cpu_bus_lsu
//   Load/store bus master between the MIPS datapath and a word-addressed,
//   Avalon-style memory bus. Each CPU byte/halfword/word access becomes one
//   word-aligned bus transaction with lane byteenables and lane-shifted store
//   data. Load data is extracted from readdata and zero- or sign-extended.
//   Misaligned (or reserved-size) requests complete with op_error and never
//   touch the bus.
//
// Ports
//   clk, reset               rising-edge clock, asynchronous active-high reset
//   op_valid/op_write/op_size/op_signed/op_addr/op_wdata
//                            CPU request, sampled only while idle
//   op_busy, op_done, op_error, op_rdata
//                            CPU status / single-cycle completion / load result
//   address, read, write, byteenable, writedata, waitrequest, readdata
//                            memory bus master side
//
// Optional feature: define MIPS_LSU_TIMEOUT_EN to abort a transaction after
// TIMEOUT_CYCLES consecutive waitrequest stalls (completes with op_error).
module mips_cpu_bus_lsu #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   input  logic        op_write,
   input  logic [1:0]  op_size,
   input  logic        op_signed,
   input  logic [31:0] op_addr,
   input  logic [31:0] op_wdata,
   output logic        op_busy,
   output logic        op_done,
   output logic        op_error,
   output logic [31:0] op_rdata,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   output logic [3:0]  byteenable,
   output logic [31:0] writedata,
   input  logic        waitrequest,
   input  logic [31:0] readdata
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RDATA, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic        wr_q, wr_d;
   logic [1:0]  size_q, size_d;
   logic        sgn_q, sgn_d;
   logic [1:0]  off_q, off_d;
   logic        err_q, err_d;
   logic [31:0] rdata_q, rdata_d;

   logic        misaligned;
   logic [3:0]  be_new;
   logic [31:0] wdata_new;

`ifdef MIPS_LSU_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_q, tmo_d;
`endif

   // Pick the addressed bytes out of the bus word and extend them.
   function automatic logic [31:0] extract(input logic [31:0] rd,
                                           input logic [1:0]  off,
                                           input logic [1:0]  size,
                                           input logic        sgn);
      logic [31:0] sh;
      sh = rd >> {off, 3'b000};
      case (size)
         2'b00:   extract = {{24{sgn & sh[7]}}, sh[7:0]};
         2'b01:   extract = {{16{sgn & sh[15]}}, sh[15:0]};
         default: extract = rd;
      endcase
   endfunction

   always_comb begin
      misaligned = (op_size == 2'b11) ||
                   ((op_size == 2'b01) && op_addr[0]) ||
                   ((op_size == 2'b10) && (op_addr[1:0] != 2'b00));
      case (op_size)
         2'b00:   be_new = 4'b0001 << op_addr[1:0];
         2'b01:   be_new = op_addr[1] ? 4'b1100 : 4'b0011;
         default: be_new = 4'b1111;
      endcase
      case (op_size)
         2'b00:   wdata_new = {24'b0, op_wdata[7:0]}  << {op_addr[1:0], 3'b000};
         2'b01:   wdata_new = {16'b0, op_wdata[15:0]} << {op_addr[1:0], 3'b000};
         default: wdata_new = op_wdata;
      endcase
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      wr_d    = wr_q;
      size_d  = size_q;
      sgn_d   = sgn_q;
      off_d   = off_q;
      err_d   = err_q;
      rdata_d = rdata_q;
`ifdef MIPS_LSU_TIMEOUT_EN
      tmo_d   = tmo_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (op_valid) begin
               if (misaligned) begin
                  // Bus registers are left alone: no bus cycle is issued.
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  addr_d  = {op_addr[31:2], 2'b00};
                  be_d    = be_new;
                  wdata_d = wdata_new;
                  wr_d    = op_write;
                  size_d  = op_size;
                  sgn_d   = op_signed;
                  off_d   = op_addr[1:0];
                  err_d   = 1'b0;
                  state_d = S_ISSUE;
`ifdef MIPS_LSU_TIMEOUT_EN
                  tmo_d   = '0;
`endif
               end
            end
         end
         S_ISSUE: begin
            if (!waitrequest) begin
               state_d = wr_q ? S_DONE : S_RDATA;
            end
`ifdef MIPS_LSU_TIMEOUT_EN
            // tmo_q counts stalls already seen; this stall is the last allowed.
            else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               tmo_d   = tmo_q + 1'b1;
            end
`endif
         end
         S_RDATA: begin
            rdata_d = extract(readdata, off_q, size_q, sgn_q);
            state_d = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         size_q  <= '0;
         sgn_q   <= 1'b0;
         off_q   <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
`ifdef MIPS_LSU_TIMEOUT_EN
         tmo_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         wr_q    <= wr_d;
         size_q  <= size_d;
         sgn_q   <= sgn_d;
         off_q   <= off_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
`ifdef MIPS_LSU_TIMEOUT_EN
         tmo_q   <= tmo_d;
`endif
      end
   end

   // Bus strobes decode from state so reset removes them immediately.
   assign read       = (state_q == S_ISSUE) && !wr_q;
   assign write      = (state_q == S_ISSUE) && wr_q;
   assign address    = addr_q;
   assign byteenable = be_q;
   assign writedata  = wdata_q;
   assign op_busy    = (state_q != S_IDLE);
   assign op_done    = (state_q == S_DONE);
   assign op_error   = (state_q == S_DONE) && err_q;
   assign op_rdata   = rdata_q;

endmodule
